// File: rtl/midori_sbox_layer_seq.sv
// Nibble-serial sequencer around the 3-share Midori G S-box stage: feeds one nibble
// plus one fresh randomness word per cycle and reassembles the shared result state.
module midori_sbox_layer_seq #(
  parameter int NIBBLES   = 16,
  parameter int G_LATENCY = 1,
  parameter int R_W       = 18,
  parameter int RS_W      = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_s1,
  input  logic [4*NIBBLES-1:0]   in_s2,
  input  logic [4*NIBBLES-1:0]   in_s3,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  input  logic [R_W+RS_W-1:0]    rnd,
  output logic [3:0]             g_in1,
  output logic [3:0]             g_in2,
  output logic [3:0]             g_in3,
  output logic [R_W-1:0]         g_r,
  output logic [RS_W-1:0]        g_rs,
  input  logic [3:0]             g_out1,
  input  logic [3:0]             g_out2,
  input  logic [3:0]             g_out3,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_s1,
  output logic [4*NIBBLES-1:0]   out_s2,
  output logic [4*NIBBLES-1:0]   out_s3,
  output logic [1:0]             dbg_state_o
);

  localparam int SW = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);
  localparam int NW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [SW-1:0]        in1_q, in2_q, in3_q;
  logic [SW-1:0]        in1_d, in2_d, in3_d;
  logic [SW-1:0]        out1_q, out2_q, out3_q;
  logic [SW-1:0]        out1_d, out2_d, out3_d;
  logic [CW-1:0]        k_q, k_d;
  logic [CW-1:0]        j_q, j_d;
  logic [G_LATENCY-1:0] vld_q, vld_d;

  logic                 issue;
  logic                 retire;
  logic [NW+1:0]        k_bit;
  logic [NW+1:0]        j_bit;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // The upstream must hold in_s* while in_valid=1 and in_ready=0; rnd_ready is only
  // high in ISSUE and a word is consumed on every edge where rnd_valid is also high.
  assign issue  = (state_q == ISSUE) && rnd_valid;
  assign retire = vld_q[G_LATENCY-1];
  assign k_bit  = {k_q[NW-1:0], 2'b00};
  assign j_bit  = {j_q[NW-1:0], 2'b00};

  always_comb begin
    rnd_ready = (state_q == ISSUE);
    g_in1     = '0;
    g_in2     = '0;
    g_in3     = '0;
    g_r       = '0;
    g_rs      = '0;
    if (issue) begin
      g_in1 = in1_q[k_bit +: 4];
      g_in2 = in2_q[k_bit +: 4];
      g_in3 = in3_q[k_bit +: 4];
      g_r   = rnd[R_W-1:0];
      g_rs  = rnd[R_W+RS_W-1:R_W];
    end
  end

  // The valid shift register mirrors the G pipeline, so bubbles never retire.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = issue;
    for (int i = 1; i < G_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    in3_d       = in3_q;
    out1_d      = out1_q;
    out2_d      = out2_q;
    out3_d      = out3_q;
    k_d         = k_q;
    j_d         = j_q;

    if (retire) begin
      out1_d[j_bit +: 4] = g_out1;
      out2_d[j_bit +: 4] = g_out2;
      out3_d[j_bit +: 4] = g_out3;
      j_d                = j_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          in1_d   = in_s1;
          in2_d   = in_s2;
          in3_d   = in_s3;
          k_d     = '0;
          j_d     = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          k_d = k_q + CW'(1);
          if (k_q == CW'(NIBBLES - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (retire && (j_q == CW'(NIBBLES - 1))) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready is registered so it rises one edge after reset release or handshake.
  assign in_ready_d = (state_d == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in1_q       <= '0;
      in2_q       <= '0;
      in3_q       <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
      out3_q      <= '0;
      k_q         <= '0;
      j_q         <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      in3_q       <= in3_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      out3_q      <= out3_d;
      k_q         <= k_d;
      j_q         <= j_d;
      vld_q       <= vld_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_s1      = out1_q;
  assign out_s2      = out2_q;
  assign out_s3      = out3_q;
  assign dbg_state_o = state_q;

endmodule
